// File: rtl/execute_stage.sv
// execute_stage: ID/EX pipeline register, two chained ALUs and EX/MEM output register.
//
// ALU1 supports a multi-cycle signed multiply. While the multiply is in progress, stall_o holds
// the PC and decode slot, and bubbles are written to EX/MEM.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   valid_d, flush    decode slot valid / squash incoming decode slot
//   *D controls       RegWrite, MemtoReg, MemWrite, ALU1Src, RegDst, ALU1/ALU2 control
//   Src1AD/BD/CD      operands A, B, C; SignImmD immediate; A2D/A3D destination candidates
//   stall_o           hold PC and InstrD
//   *E outputs        registered EX/MEM fields, with valid_e qualifying them
module execute_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_d,
    input  logic        flush,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic        ALU1SrcD,
    input  logic        RegDstD,
    input  logic [2:0]  ALU1CntrlD,
    input  logic [2:0]  ALU2CntrlD,
    input  logic [31:0] Src1AD,
    input  logic [31:0] Src1BD,
    input  logic [31:0] Src1CD,
    input  logic [31:0] SignImmD,
    input  logic [5:0]  A2D,
    input  logic [5:0]  A3D,
    output logic        stall_o,
    output logic        valid_e,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic [5:0]  WriteRegE,
    output logic [31:0] ALUResultE,
    output logic [31:0] WriteDataE
);

    typedef enum logic {StIdle, StBusy} state_e;

    // ID/EX register
    logic        valid_q, valid_d_n;
    logic        reg_write_q, reg_write_d;
    logic        memto_reg_q, memto_reg_d;
    logic        mem_write_q, mem_write_d;
    logic        alu1_src_q, alu1_src_d;
    logic [2:0]  alu1_cntrl_q, alu1_cntrl_d;
    logic [2:0]  alu2_cntrl_q, alu2_cntrl_d;
    logic [31:0] src_a_q, src_a_d;
    logic [31:0] src_b_q, src_b_d;
    logic [31:0] src_c_q, src_c_d;
    logic [31:0] sign_imm_q, sign_imm_d;
    logic [5:0]  write_reg_q, write_reg_d;

    // Multiply sequencing
    logic [1:0]  cnt_q, cnt_d;
    state_e      state_q, state_d;

    // EX/MEM register
    logic        ex_valid_q, ex_valid_d;
    logic        ex_reg_write_q, ex_reg_write_d;
    logic        ex_memto_reg_q, ex_memto_reg_d;
    logic        ex_mem_write_q, ex_mem_write_d;
    logic [5:0]  ex_write_reg_q, ex_write_reg_d;
    logic [31:0] ex_result_q, ex_result_d;
    logic [31:0] ex_write_data_q, ex_write_data_d;

    logic        stall;
    logic        load_valid;
    logic [31:0] src_b_sel;
    logic [31:0] mul_res;
    logic [31:0] alu1_res;
    logic [31:0] alu2_res;

    // Stall is decoded from registers only, so it never depends on decode-side inputs.
    assign stall   = valid_q & (alu1_cntrl_q == 3'b101) & (cnt_q != 2'd3);
    assign stall_o = stall;

    assign src_b_sel = alu1_src_q ? sign_imm_q : src_b_q;
    // Low 32 bits of a two's-complement product are independent of signedness.
    assign mul_res   = src_a_q * src_b_sel;

    always_comb begin
        alu1_res = src_b_sel;
        unique case (alu1_cntrl_q)
            3'b000: alu1_res = src_a_q + src_b_sel;
            3'b001: alu1_res = src_a_q - src_b_sel;
            3'b010: alu1_res = src_a_q & src_b_sel;
            3'b011: alu1_res = src_a_q | src_b_sel;
            3'b100: alu1_res = {31'd0, $signed(src_a_q) < $signed(src_b_sel)};
            3'b101: alu1_res = mul_res;
            3'b110: alu1_res = src_a_q[31] ? 32'd0 : src_a_q;
            3'b111: alu1_res = src_b_sel;
        endcase
    end

    always_comb begin
        alu2_res = alu1_res;
        case (alu2_cntrl_q)
            3'b001:  alu2_res = alu1_res + src_c_q;
            3'b010:  alu2_res = alu1_res - src_c_q;
            3'b011:  alu2_res = alu1_res[31] ? 32'd0 : alu1_res;
            default: alu2_res = alu1_res;
        endcase
    end

    // ID/EX next state: hold on stall (flush is ignored then), else load or insert a bubble.
    always_comb begin
        load_valid   = valid_d & ~flush;
        valid_d_n    = valid_q;
        reg_write_d  = reg_write_q;
        memto_reg_d  = memto_reg_q;
        mem_write_d  = mem_write_q;
        alu1_src_d   = alu1_src_q;
        alu1_cntrl_d = alu1_cntrl_q;
        alu2_cntrl_d = alu2_cntrl_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        src_c_d      = src_c_q;
        sign_imm_d   = sign_imm_q;
        write_reg_d  = write_reg_q;
        if (!stall) begin
            valid_d_n    = load_valid;
            reg_write_d  = RegWriteD & load_valid;
            memto_reg_d  = MemtoRegD & load_valid;
            mem_write_d  = MemWriteD & load_valid;
            alu1_src_d   = ALU1SrcD;
            alu1_cntrl_d = ALU1CntrlD;
            alu2_cntrl_d = ALU2CntrlD;
            src_a_d      = Src1AD;
            src_b_d      = Src1BD;
            src_c_d      = Src1CD;
            sign_imm_d   = SignImmD;
            write_reg_d  = RegDstD ? A3D : A2D;
        end
    end

    // Multiply counter: counts stall cycles, clears on the completion edge (BUSY with cnt=3).
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (stall) begin
            cnt_d   = cnt_q + 2'd1;
            state_d = StBusy;
        end else if (state_q == StBusy) begin
            cnt_d   = 2'd0;
            state_d = StIdle;
        end
    end

    // EX/MEM next state: bubble during stall, otherwise the ID/EX fields and ALU2 result.
    always_comb begin
        ex_valid_d      = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_memto_reg_d  = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_write_reg_d  = ex_write_reg_q;
        ex_result_d     = ex_result_q;
        ex_write_data_d = ex_write_data_q;
        if (!stall) begin
            ex_valid_d      = valid_q;
            ex_reg_write_d  = reg_write_q & valid_q;
            ex_memto_reg_d  = memto_reg_q & valid_q;
            ex_mem_write_d  = mem_write_q & valid_q;
            ex_write_reg_d  = write_reg_q;
            ex_result_d     = alu2_res;
            ex_write_data_d = src_b_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            memto_reg_q     <= 1'b0;
            mem_write_q     <= 1'b0;
            alu1_src_q      <= 1'b0;
            alu1_cntrl_q    <= 3'd0;
            alu2_cntrl_q    <= 3'd0;
            src_a_q         <= 32'd0;
            src_b_q         <= 32'd0;
            src_c_q         <= 32'd0;
            sign_imm_q      <= 32'd0;
            write_reg_q     <= 6'd0;
            cnt_q           <= 2'd0;
            state_q         <= StIdle;
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_memto_reg_q  <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_write_reg_q  <= 6'd0;
            ex_result_q     <= 32'd0;
            ex_write_data_q <= 32'd0;
        end else begin
            valid_q         <= valid_d_n;
            reg_write_q     <= reg_write_d;
            memto_reg_q     <= memto_reg_d;
            mem_write_q     <= mem_write_d;
            alu1_src_q      <= alu1_src_d;
            alu1_cntrl_q    <= alu1_cntrl_d;
            alu2_cntrl_q    <= alu2_cntrl_d;
            src_a_q         <= src_a_d;
            src_b_q         <= src_b_d;
            src_c_q         <= src_c_d;
            sign_imm_q      <= sign_imm_d;
            write_reg_q     <= write_reg_d;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            ex_valid_q      <= ex_valid_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_memto_reg_q  <= ex_memto_reg_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_write_reg_q  <= ex_write_reg_d;
            ex_result_q     <= ex_result_d;
            ex_write_data_q <= ex_write_data_d;
        end
    end

    assign valid_e    = ex_valid_q;
    assign RegWriteE  = ex_reg_write_q;
    assign MemtoRegE  = ex_memto_reg_q;
    assign MemWriteE  = ex_mem_write_q;
    assign WriteRegE  = ex_write_reg_q;
    assign ALUResultE = ex_result_q;
    assign WriteDataE = ex_write_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected results with their due cycle;
// a monitor pops and compares whenever valid_e is high.
module tb_execute_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        valid_d = 1'b0, flush = 1'b0;
    logic        RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0;
    logic        ALU1SrcD = 1'b0, RegDstD = 1'b0;
    logic [2:0]  ALU1CntrlD = 3'd0, ALU2CntrlD = 3'd0;
    logic [31:0] Src1AD = 32'd0, Src1BD = 32'd0, Src1CD = 32'd0, SignImmD = 32'd0;
    logic [5:0]  A2D = 6'd0, A3D = 6'd0;
    logic        stall_o, valid_e, RegWriteE, MemtoRegE, MemWriteE;
    logic [5:0]  WriteRegE;
    logic [31:0] ALUResultE, WriteDataE;

    execute_stage dut (
        .CLK(CLK), .RST(RST), .valid_d(valid_d), .flush(flush),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALU1SrcD(ALU1SrcD), .RegDstD(RegDstD), .ALU1CntrlD(ALU1CntrlD),
        .ALU2CntrlD(ALU2CntrlD), .Src1AD(Src1AD), .Src1BD(Src1BD), .Src1CD(Src1CD),
        .SignImmD(SignImmD), .A2D(A2D), .A3D(A3D), .stall_o(stall_o), .valid_e(valid_e),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .WriteRegE(WriteRegE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  wreg;
        logic        rw, mw, m2r;
        logic [31:0] wd;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic [5:0] wreg, input logic rw,
                                input logic mw, input logic m2r, input logic [31:0] wd);
        exp_t e;
        e.res = res; e.wreg = wreg; e.rw = rw; e.mw = mw; e.m2r = m2r; e.wd = wd; e.due = 0;
        return e;
    endfunction

    // Monitor: every cycle, #1 after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST && valid_e) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid_e", 32'(valid_e), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("due_cycle", 32'(cyc), 32'(e.due));
                    chk("ALUResultE", ALUResultE, e.res);
                    chk("WriteRegE", 32'(WriteRegE), 32'(e.wreg));
                    chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
                    chk("MemWriteE", 32'(MemWriteE), 32'(e.mw));
                    chk("MemtoRegE", 32'(MemtoRegE), 32'(e.m2r));
                    chk("WriteDataE", WriteDataE, e.wd);
                end
            end else if (!valid_e) begin
                chk("ctrl_zero_when_invalid", {29'd0, RegWriteE, MemWriteE, MemtoRegE}, 32'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic fl, input logic rw, input logic m2r,
                         input logic mw, input logic a1src, input logic rdst,
                         input logic [2:0] c1, input logic [2:0] c2,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] imm, input logic [5:0] a2, input logic [5:0] a3);
        valid_d = v; flush = fl; RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw;
        ALU1SrcD = a1src; RegDstD = rdst; ALU1CntrlD = c1; ALU2CntrlD = c2;
        Src1AD = a; Src1BD = b; Src1CD = c; SignImmD = imm; A2D = a2; A3D = a3;
    endtask

    // Clock the driven slot in, record the expectation, ride out any stall.
    task automatic run(input bit push, input exp_t e, input int lat, input int exp_stall,
                       input bit flush_mid);
        int n;
        exp_t x;
        x = e;
        @(posedge CLK);
        #1;
        if (push) begin
            x.due = cyc + lat;
            sb.push_back(x);
        end
        n = 0;
        while (stall_o && n < 10) begin
            n++;
            if (flush_mid && n == 1) flush = 1'b1;
            @(posedge CLK);
            #1;
        end
        flush = 1'b0;
        chk("stall_cycles", 32'(n), 32'(exp_stall));
        @(negedge CLK);
    endtask

    task automatic bubbles(input int k);
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < k; i++) begin
            drive(0, 0, 1, 1, 1, 0, 0, 3'd0, 3'd0, 32'd1, 32'd1, 32'd0, 32'd0, 6'd1, 6'd2);
            run(0, e, 0, 0, 0);
        end
    endtask

    initial begin
        exp_t none;
        none = mk(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_stall_o", 32'(stall_o), 32'd0);
        chk("rst_valid_e", 32'(valid_e), 32'd0);
        chk("rst_ALUResultE", ALUResultE, 32'd0);
        chk("rst_WriteRegE", 32'(WriteRegE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Add, RegDst selects A3
        drive(1, 0, 1, 0, 0, 0, 1, 3'b000, 3'b000, 32'd5, 32'd7, 32'd0, 32'd0, 6'd3, 6'd9);
        run(1, mk(32'd12, 6'd9, 1, 0, 0, 32'd7), 1, 0, 0);
        // Sub with negative result, RegDst selects A2, store
        drive(1, 0, 0, 0, 1, 0, 0, 3'b001, 3'b000, 32'd5, 32'd7, 32'd0, 32'd0, 6'd4, 6'd8);
        run(1, mk(32'hFFFF_FFFE, 6'd4, 0, 1, 0, 32'd7), 1, 0, 0);
        // AND then +C
        drive(1, 0, 1, 1, 0, 0, 0, 3'b010, 3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd1,
              32'd0, 6'd5, 6'd0);
        run(1, mk(32'h00F0_1235, 6'd5, 1, 0, 1, 32'h0FF0_FFFF), 1, 0, 0);
        // OR then -C
        drive(1, 0, 1, 0, 0, 0, 1, 3'b011, 3'b010, 32'h1200_0000, 32'h0000_0034, 32'd4,
              32'd0, 6'd0, 6'd6);
        run(1, mk(32'h1200_0030, 6'd6, 1, 0, 0, 32'h34), 1, 0, 0);
        // Signed less-than both ways
        drive(1, 0, 1, 0, 0, 0, 1, 3'b100, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 6'd0,
              6'd7);
        run(1, mk(32'd1, 6'd7, 1, 0, 0, 32'd1), 1, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 1, 3'b100, 3'b000, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd0,
              6'd8);
        run(1, mk(32'd0, 6'd8, 1, 0, 0, 32'hFFFF_FFFF), 1, 0, 0);
        // ReLU on ALU1
        drive(1, 0, 1, 0, 0, 0, 1, 3'b110, 3'b000, 32'h8000_0001, 32'd0, 32'd0, 32'd0, 6'd0,
              6'd10);
        run(1, mk(32'd0, 6'd10, 1, 0, 0, 32'd0), 1, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 1, 3'b110, 3'b000, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 6'd0,
              6'd11);
        run(1, mk(32'h7FFF_FFFF, 6'd11, 1, 0, 0, 32'd0), 1, 0, 0);
        // Wrapping add, then ReLU on ALU2 of the same sum
        drive(1, 0, 1, 0, 0, 0, 1, 3'b000, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 6'd0,
              6'd12);
        run(1, mk(32'h8000_0000, 6'd12, 1, 0, 0, 32'd1), 1, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 1, 3'b000, 3'b011, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 6'd0,
              6'd13);
        run(1, mk(32'd0, 6'd13, 1, 0, 0, 32'd1), 1, 0, 0);
        // Pass SrcB from immediate; WriteData still the B register
        drive(1, 0, 1, 0, 0, 1, 1, 3'b111, 3'b000, 32'd9, 32'h55, 32'd0, 32'h1234, 6'd0,
              6'd14);
        run(1, mk(32'h1234, 6'd14, 1, 0, 0, 32'h55), 1, 0, 0);
        // ALU2 codes 1xx pass R
        drive(1, 0, 1, 0, 0, 0, 1, 3'b000, 3'b110, 32'd2, 32'd3, 32'd100, 32'd0, 6'd0, 6'd15);
        run(1, mk(32'd5, 6'd15, 1, 0, 0, 32'd3), 1, 0, 0);

        // MAC with immediate: 3 * -2 + 10
        drive(1, 0, 1, 0, 0, 1, 1, 3'b101, 3'b001, 32'd3, 32'h99, 32'd10, 32'hFFFF_FFFE,
              6'd0, 6'd16);
        run(1, mk(32'd4, 6'd16, 1, 0, 0, 32'h99), 4, 3, 0);
        // Back-to-back multiplies, then an add with no residual stall
        drive(1, 0, 1, 0, 0, 0, 1, 3'b101, 3'b000, 32'hFFFF_FFFC, 32'd5, 32'd0, 32'd0, 6'd0,
              6'd17);
        run(1, mk(32'hFFFF_FFEC, 6'd17, 1, 0, 0, 32'd5), 4, 3, 0);
        drive(1, 0, 1, 0, 0, 0, 1, 3'b101, 3'b000, 32'h0001_0003, 32'h0001_0000, 32'd0,
              32'd0, 6'd0, 6'd18);
        run(1, mk(32'h0003_0000, 6'd18, 1, 0, 0, 32'h0001_0000), 4, 3, 0);
        drive(1, 0, 1, 0, 0, 0, 1, 3'b000, 3'b000, 32'd20, 32'd22, 32'd0, 32'd0, 6'd0, 6'd19);
        run(1, mk(32'd42, 6'd19, 1, 0, 0, 32'd22), 1, 0, 0);

        // Flushed add produces a bubble
        drive(1, 1, 1, 0, 1, 0, 1, 3'b000, 3'b000, 32'd1, 32'd2, 32'd0, 32'd0, 6'd0, 6'd20);
        run(0, none, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd0);
        @(posedge CLK);
        #1;
        chk("flush_valid_e", 32'(valid_e), 32'd0);
        chk("flush_RegWriteE", 32'(RegWriteE), 32'd0);
        @(negedge CLK);
        // Flush during multiply stall is ignored
        drive(1, 0, 1, 0, 0, 0, 1, 3'b101, 3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 6'd0, 6'd21);
        run(1, mk(32'd42, 6'd21, 1, 0, 0, 32'd6), 4, 3, 1);
        // valid_d=0 with controls set: bubble
        bubbles(4);
        chk("drained_before_reset", 32'(sb.size()), 32'd0);

        // Reset on the 2nd stall cycle of a multiply
        drive(1, 0, 1, 0, 0, 0, 1, 3'b101, 3'b000, 32'd9, 32'd9, 32'd0, 32'd0, 6'd0, 6'd22);
        @(posedge CLK);
        #1;
        chk("mul_stall_1", 32'(stall_o), 32'd1);
        @(posedge CLK);
        #1;
        chk("mul_stall_2", 32'(stall_o), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_stall_o", 32'(stall_o), 32'd0);
        chk("midrst_valid_e", 32'(valid_e), 32'd0);
        chk("midrst_ALUResultE", ALUResultE, 32'd0);
        chk("midrst_RegWriteE", 32'(RegWriteE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 0, 1, 0, 0, 0, 1, 3'b000, 3'b000, 32'd1, 32'd1, 32'd0, 32'd0, 6'd0, 6'd23);
        run(1, mk(32'd2, 6'd23, 1, 0, 0, 32'd1), 1, 0, 0);
        bubbles(3);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
